// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the ifu/lsu memory-bus arbiter.
package mem_arbiter_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ArbIdle = 2'b00,
      ArbReq  = 2'b01,
      ArbResp = 2'b10
   } arb_state_e;

   localparam logic OwnIfu = 1'b0;
   localparam logic OwnLsu = 1'b1;

   localparam logic [2:0] MemOpWord = 3'b010;

endpackage

// File: rtl/mem_arbiter_arb_pick2.sv
// Two-way requester picker. Fixed LSU priority by default; define MEM_ARB_RR_EN to hand
// contention to whichever requester did not own the last completed transaction.
module mem_arbiter_arb_pick2
   import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic       last_owner_i,
`endif
   input  logic       ifu_valid_i,
   input  logic       lsu_valid_i,
   output logic [1:0] gnt_o          // {lsu, ifu}
);

   logic prefer_ifu;

`ifdef MEM_ARB_RR_EN
   assign prefer_ifu = (last_owner_i == OwnLsu);
`else
   assign prefer_ifu = 1'b0;
`endif

   assign gnt_o[0] = ifu_valid_i && (!lsu_valid_i || prefer_ifu);
   assign gnt_o[1] = lsu_valid_i && (!ifu_valid_i || !prefer_ifu);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between fetch (ifu) and load/store (lsu).
// Optional round-robin contention handling is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned AW = XLEN,
   parameter int unsigned DW = XLEN
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ifu_valid,
   input  logic [AW-1:0] ifu_addr,
   output logic          ifu_ready,
   output logic          ifu_rvalid,
   output logic [31:0]   ifu_rdata,
   input  logic          lsu_valid,
   input  logic          lsu_wr,
   input  logic [2:0]    lsu_op,
   input  logic [AW-1:0] lsu_addr,
   input  logic [DW-1:0] lsu_wdata,
   output logic          lsu_ready,
   output logic          lsu_rvalid,
   output logic [DW-1:0] lsu_rdata,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [2:0]    mem_op,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_e    state_q;
   logic          owner_q;
   logic          mem_req_q;
   logic          mem_wr_q;
   logic [2:0]    mem_op_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [1:0]    gnt;
   logic          resp_done;

`ifdef MEM_ARB_RR_EN
   logic          last_owner_q;
`endif

   mem_arbiter_arb_pick2 u_pick (
`ifdef MEM_ARB_RR_EN
      .last_owner_i (last_owner_q),
`endif
      .ifu_valid_i  (ifu_valid),
      .lsu_valid_i  (lsu_valid),
      .gnt_o        (gnt)
   );

   // Readies are masked by reset so nothing looks accepted while the block is held in reset.
   assign ifu_ready  = rst_n && (state_q == ArbIdle) && gnt[0];
   assign lsu_ready  = rst_n && (state_q == ArbIdle) && gnt[1];

   assign resp_done  = (state_q == ArbResp) && mem_rvalid;
   assign ifu_rvalid = resp_done && (owner_q == OwnIfu);
   assign lsu_rvalid = resp_done && (owner_q == OwnLsu);
   assign ifu_rdata  = ifu_rvalid ? mem_rdata[31:0] : 32'h0;
   assign lsu_rdata  = (lsu_rvalid && !mem_wr_q) ? mem_rdata : '0;

   assign mem_req    = mem_req_q;
   assign mem_wr     = mem_wr_q;
   assign mem_op     = mem_op_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ArbIdle;
         owner_q      <= OwnLsu;
         mem_req_q    <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_op_q     <= 3'b000;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= OwnIfu;
`endif
      end else begin
         unique case (state_q)
            ArbIdle: begin
               if (gnt[1]) begin
                  owner_q     <= OwnLsu;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= lsu_wr;
                  mem_op_q    <= lsu_op;
                  mem_addr_q  <= lsu_addr;
                  mem_wdata_q <= lsu_wdata;
                  state_q     <= ArbReq;
               end else if (gnt[0]) begin
                  owner_q     <= OwnIfu;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= 1'b0;
                  mem_op_q    <= MemOpWord;
                  mem_addr_q  <= ifu_addr;
                  mem_wdata_q <= '0;
                  state_q     <= ArbReq;
               end
            end
            ArbReq: begin
               if (mem_gnt) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ArbResp;
               end
            end
            ArbResp: begin
               if (mem_rvalid) begin
                  state_q      <= ArbIdle;
`ifdef MEM_ARB_RR_EN
                  last_owner_q <= owner_q;
`endif
               end
            end
            default: state_q <= ArbIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table, corner sequences and a
// randomized run against a transaction-level model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_valid, ifu_ready, ifu_rvalid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_valid, lsu_wr, lsu_ready, lsu_rvalid;
   logic [2:0]  lsu_op;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic        mem_req, mem_wr, mem_gnt, mem_rvalid;
   logic [2:0]  mem_op;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_err = 0;
   int n_chk = 0;

   mem_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ifu_valid  (ifu_valid),
      .ifu_addr   (ifu_addr),
      .ifu_ready  (ifu_ready),
      .ifu_rvalid (ifu_rvalid),
      .ifu_rdata  (ifu_rdata),
      .lsu_valid  (lsu_valid),
      .lsu_wr     (lsu_wr),
      .lsu_op     (lsu_op),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_ready  (lsu_ready),
      .lsu_rvalid (lsu_rvalid),
      .lsu_rdata  (lsu_rdata),
      .mem_req    (mem_req),
      .mem_wr     (mem_wr),
      .mem_op     (mem_op),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifu_valid = 1'b0; ifu_addr = 32'h0;
      lsu_valid = 1'b0; lsu_wr = 1'b0; lsu_op = 3'b000; lsu_addr = 32'h0; lsu_wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
   endtask

   // Leaves the bench at posedge+1 with reset released.
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        iv, lv, lwr;
      logic [2:0]  lop;
      logic [31:0] iaddr, laddr, lwdata, rdata;
      int          gnt_dly, rv_dly;
      logic        e_iready, e_lready, e_wr;
      logic [2:0]  e_op;
      logic [31:0] e_addr, e_wdata, e_irdata, e_lrdata;
   } vec_t;

   task automatic run_vec(input int idx, input vec_t v);
      string p;
      bit    last;
      p = $sformatf("v%0d_", idx);
      do_reset();
      ifu_valid = v.iv; ifu_addr = v.iaddr;
      lsu_valid = v.lv; lsu_wr = v.lwr; lsu_op = v.lop; lsu_addr = v.laddr; lsu_wdata = v.lwdata;
      @(negedge clk);
      chk({p, "ifu_ready"}, ifu_ready, v.e_iready);
      chk({p, "lsu_ready"}, lsu_ready, v.e_lready);
      tick();
      // Both requesters keep asking while the bus is busy; nothing may be accepted.
      ifu_valid = 1'b1; lsu_valid = 1'b1;
      ifu_addr = 32'h1234_5678; lsu_addr = 32'h8765_4320; lsu_wdata = 32'h0BAD_0BAD;
      for (int c = 0; c <= v.gnt_dly; c++) begin
         mem_gnt = (c == v.gnt_dly);
         @(negedge clk);
         chk({p, "mem_req"}, mem_req, 1'b1);
         chk({p, "mem_addr"}, mem_addr, v.e_addr);
         chk({p, "busy_ready"}, {ifu_ready, lsu_ready}, 2'b00);
         if (c == 0) begin
            chk({p, "mem_wr"}, mem_wr, v.e_wr);
            chk({p, "mem_op"}, mem_op, v.e_op);
            chk({p, "mem_wdata"}, mem_wdata, v.e_wdata);
         end
         tick();
      end
      mem_gnt = 1'b0;
      for (int c = 0; c <= v.rv_dly; c++) begin
         last = (c == v.rv_dly);
         mem_rvalid = last;
         mem_rdata  = last ? v.rdata : 32'hFFFF_0000;
         if (last) begin
            ifu_valid = 1'b0;
            lsu_valid = 1'b0;
         end
         @(negedge clk);
         chk({p, "resp_mem_req"}, mem_req, 1'b0);
         chk({p, "ifu_rvalid"}, ifu_rvalid, last && v.e_iready);
         chk({p, "lsu_rvalid"}, lsu_rvalid, last && v.e_lready);
         if (last && v.e_iready) chk({p, "ifu_rdata"}, ifu_rdata, v.e_irdata);
         if (last && v.e_lready) chk({p, "lsu_rdata"}, lsu_rdata, v.e_lrdata);
         tick();
      end
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk({p, "after_ready"}, {ifu_ready, lsu_ready}, 2'b00);
      tick();
      @(negedge clk);
      chk({p, "after_mem_req"}, mem_req, 1'b0);
      tick();
   endtask

   // Transaction-level reference model for the random run.
   logic        m_act, m_granted, m_own_lsu, m_wr, m_last_lsu;
   logic [2:0]  m_op;
   logic [31:0] m_addr, m_wdata;

   function automatic logic lsu_wins_tie();
`ifdef MEM_ARB_RR_EN
      return !m_last_lsu;
`else
      return 1'b1;
`endif
   endfunction

   vec_t vecs[6];
   logic exp_ir, exp_lr, resp, acc_i, acc_l, rr_ifu;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0013, 0, 1,
                  1'b1, 1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h0000_0013, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 3'b100, 32'h0, 32'h8000_2004, 32'h1111_1111, 32'hCAFE_F00D,
                  0, 0, 1'b0, 1'b1, 1'b0, 3'b100, 32'h8000_2004, 32'h1111_1111, 32'h0,
                  32'hCAFE_F00D};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h8000_1000, 32'hDEAD_BEEF,
                  32'h0000_0055, 0, 0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h8000_1000, 32'hDEAD_BEEF,
                  32'h0, 32'h0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h8000_0008, 32'h8000_0FFE, 32'h0, 32'hA5A5_A5A5,
                  1, 0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h8000_0FFE, 32'h0, 32'h0, 32'hA5A5_A5A5};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b111, 32'h0000_0004, 32'h0, 32'h0, 32'hFFFF_FFFF, 5, 0,
                  1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'hFFFF_FFFF, 32'h0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 3'b000, 32'h0, 32'h0000_0003, 32'h0000_00FF, 32'h1234_5678,
                  1, 2, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00FF, 32'h0, 32'h0};

      // Reset state, with requests and a response already present on the inputs.
      rst_n = 1'b0;
      idle_inputs();
      ifu_valid = 1'b1; lsu_valid = 1'b1; mem_rvalid = 1'b1; mem_gnt = 1'b1;
      #12;
      chk("rst_ready", {ifu_ready, lsu_ready}, 2'b00);
      chk("rst_rvalid", {ifu_rvalid, lsu_rvalid}, 2'b00);
      chk("rst_mem", {mem_req, mem_wr, mem_op, mem_addr, mem_wdata}, 69'h0);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Store wins contention, then the next contention follows the arbitration policy.
`ifdef MEM_ARB_RR_EN
      rr_ifu = 1'b1;
`else
      rr_ifu = 1'b0;
`endif
      do_reset();
      ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
      lsu_valid = 1'b1; lsu_wr = 1'b1; lsu_op = 3'b010;
      lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("b2b_first_lsu_ready", {ifu_ready, lsu_ready}, 2'b01);
      tick();
      lsu_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      chk("b2b_store", {mem_wr, mem_wdata}, {1'b1, 32'hDEAD_BEEF});
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      lsu_valid = 1'b1; lsu_wr = 1'b0; lsu_addr = 32'h8000_1004;
      @(negedge clk);
      chk("b2b_store_ack", {lsu_rvalid, ifu_rvalid, lsu_rdata}, {2'b10, 32'h0});
      tick();
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("b2b_second_pick", {ifu_ready, lsu_ready}, {rr_ifu, !rr_ifu});
      tick();
      if (rr_ifu) ifu_valid = 1'b0; else lsu_valid = 1'b0;
      mem_gnt = 1'b1;
      @(negedge clk);
      chk("b2b_second_addr", mem_addr, rr_ifu ? 32'h8000_0000 : 32'h8000_1004);
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("b2b_loser_next", {ifu_ready, lsu_ready}, {!rr_ifu, rr_ifu});
      tick();

      // Asynchronous reset in RESP, then a late response after reset.
      do_reset();
      ifu_valid = 1'b1; ifu_addr = 32'h8000_0040;
      tick();
      ifu_valid = 1'b0; mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
      @(negedge clk);
      chk("arst_pre_rvalid", ifu_rvalid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_rvalid", {ifu_rvalid, lsu_rvalid}, 2'b00);
      chk("arst_mem", {mem_req, mem_wr, mem_op, mem_addr, mem_wdata}, 69'h0);
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_late_rvalid", {ifu_rvalid, lsu_rvalid, mem_req}, 3'b000);
      tick();
      mem_rvalid = 1'b0;

      // Spurious responses in IDLE and REQ are ignored.
      do_reset();
      mem_rvalid = 1'b1; mem_rdata = 32'hBADD_BADD;
      @(negedge clk);
      chk("spur_idle_rvalid", {ifu_rvalid, lsu_rvalid}, 2'b00);
      tick();
      lsu_valid = 1'b1; lsu_addr = 32'h8000_0100;
      tick();
      lsu_valid = 1'b0;
      @(negedge clk);
      chk("spur_req_rvalid", {ifu_rvalid, lsu_rvalid, mem_req}, 3'b001);
      tick();
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("spur_req_held", mem_req, 1'b1);
      tick();

      // Randomized run against the transaction model.
      do_reset();
      m_act = 1'b0; m_granted = 1'b0; m_last_lsu = 1'b0; m_own_lsu = 1'b0;
      m_wr = 1'b0; m_op = 3'b000; m_addr = 32'h0; m_wdata = 32'h0;
      acc_i = 1'b0; acc_l = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (acc_i) ifu_valid = 1'b0;
         if (!ifu_valid) begin
            if ($urandom_range(2) == 0) begin
               ifu_valid = 1'b1;
               ifu_addr  = $urandom & ~32'h3;
            end
         end else if ($urandom_range(9) == 0) ifu_valid = 1'b0;
         if (acc_l) lsu_valid = 1'b0;
         if (!lsu_valid) begin
            if ($urandom_range(2) == 0) begin
               lsu_valid = 1'b1;
               lsu_wr    = 1'($urandom_range(1));
               lsu_op    = 3'($urandom_range(7));
               lsu_addr  = $urandom;
               lsu_wdata = $urandom;
            end
         end else if ($urandom_range(9) == 0) lsu_valid = 1'b0;
         mem_gnt    = 1'($urandom_range(1));
         mem_rvalid = ($urandom_range(2) == 0);
         mem_rdata  = $urandom;

         exp_lr = !m_act && lsu_valid && (!ifu_valid || lsu_wins_tie());
         exp_ir = !m_act && ifu_valid && !exp_lr;
         resp   = m_act && m_granted && mem_rvalid;
         @(negedge clk);
         chk("rnd_ifu_ready", ifu_ready, exp_ir);
         chk("rnd_lsu_ready", lsu_ready, exp_lr);
         chk("rnd_ifu_rvalid", ifu_rvalid, resp && !m_own_lsu);
         chk("rnd_lsu_rvalid", lsu_rvalid, resp && m_own_lsu);
         chk("rnd_mem_req", mem_req, m_act && !m_granted);
         if (m_act) chk("rnd_payload", {mem_wr, mem_op, mem_addr, mem_wdata},
                        {m_wr, m_op, m_addr, m_wdata});
         if (resp && !m_own_lsu) chk("rnd_ifu_rdata", ifu_rdata, mem_rdata);
         if (resp && m_own_lsu) chk("rnd_lsu_rdata", lsu_rdata, m_wr ? 32'h0 : mem_rdata);

         if (exp_lr) begin
            m_act = 1'b1; m_granted = 1'b0; m_own_lsu = 1'b1;
            m_wr = lsu_wr; m_op = lsu_op; m_addr = lsu_addr; m_wdata = lsu_wdata;
         end else if (exp_ir) begin
            m_act = 1'b1; m_granted = 1'b0; m_own_lsu = 1'b0;
            m_wr = 1'b0; m_op = 3'b010; m_addr = ifu_addr; m_wdata = 32'h0;
         end else if (m_act && !m_granted && mem_gnt) begin
            m_granted = 1'b1;
         end else if (resp) begin
            m_act = 1'b0;
            m_last_lsu = m_own_lsu;
         end
         acc_i = exp_ir;
         acc_l = exp_lr;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
